// File: rtl/serial_add_ctrl_if.sv
//------------------------------------------------------------------------------
// Module   : serial_add_ctrl_if
// Purpose  : Operand/result handshake bundle for the bit-serial adder.
// Revision : 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface serial_add_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
   logic             out_carry;
   logic             busy;

   // The producer/consumer side that drives operands and accepts results.
   modport master (
      output in_valid,
      output in_a,
      output in_b,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_sum,
      input  out_carry,
      input  busy
   );

   // The adder side.
   modport slave (
      input  in_valid,
      input  in_a,
      input  in_b,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_sum,
      output out_carry,
      output busy
   );
endinterface

`default_nettype wire

// File: rtl/serial_add_ctrl.sv
//------------------------------------------------------------------------------
// Module   : serial_add_ctrl (with helper half_adder)
// Purpose  : Bit-serial adder, one full-adder step per clock, valid/ready I/O.
// Revision : 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module half_adder (
   input  wire logic a_i,
   input  wire logic b_i,
   output logic      sum_o,
   output logic      carry_o
);
   // One-hot decode of the three non-zero input codes {a,b} = 01, 10, 11.
   logic [2:0] w_dec;

   assign w_dec   = {a_i & b_i, a_i & ~b_i, ~a_i & b_i};
   assign sum_o   = w_dec[0] | w_dec[1];
   assign carry_o = w_dec[2];
endmodule

module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  wire logic         clk,
   input  wire logic         rst,
   serial_add_ctrl_if.slave  bus
);
   localparam int              CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q,     a_d;
   logic [WIDTH-1:0] b_q,     b_d;
   logic [WIDTH-1:0] res_q,   res_d;
   logic [WIDTH-1:0] sum_q,   sum_d;
   logic             carry_q, carry_d;
   logic             cout_q,  cout_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;

   logic             w_ha1_sum;
   logic             w_ha1_carry;
   logic             w_ha2_sum;
   logic             w_ha2_carry;
   logic             w_carry_next;
   logic [WIDTH-1:0] w_res_shift;

   half_adder u_ha1 (
      .a_i     (a_q[0]),
      .b_i     (b_q[0]),
      .sum_o   (w_ha1_sum),
      .carry_o (w_ha1_carry)
   );

   half_adder u_ha2 (
      .a_i     (w_ha1_sum),
      .b_i     (carry_q),
      .sum_o   (w_ha2_sum),
      .carry_o (w_ha2_carry)
   );

   assign w_carry_next = w_ha1_carry | w_ha2_carry;
   assign w_res_shift  = {w_ha2_sum, res_q[WIDTH-1:1]};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      cnt_d   = cnt_q;

      unique case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               a_d     = bus.in_a;
               b_d     = bus.in_b;
               res_d   = '0;
               carry_d = 1'b0;
               cnt_d   = '0;
               state_d = RUN;
            end
         end

         RUN: begin
            res_d   = w_res_shift;
            carry_d = w_carry_next;
            a_d     = {1'b0, a_q[WIDTH-1:1]};
            b_d     = {1'b0, b_q[WIDTH-1:1]};
            cnt_d   = cnt_q + CNT_W'(1);
            // Last bit: publish the shifted result, not the stale res_q.
            if (cnt_q == CNT_LAST) begin
               sum_d   = w_res_shift;
               cout_d  = w_carry_next;
               state_d = DONE;
            end
         end

         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.busy      = (state_q != IDLE);
   assign bus.out_sum   = sum_q;
   assign bus.out_carry = cout_q;
endmodule

`default_nettype wire
